dlsc_pcie_s6_outbound_read_split: RTL and testbench



---
 rtl/dlsc_pcie_s6_outbound_read_split_pkg.sv | 34 +++
 rtl/dlsc_pcie_s6_read_seg_calc.sv | 23 ++
 rtl/dlsc_pcie_s6_outbound_read_split.sv | 128 ++++++++++++
 tb/tb_dlsc_pcie_s6_outbound_read_split.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlsc_pcie_s6_outbound_read_split_pkg.sv
// Shared PCIe read-split definitions: MRRS encodings, MRRS-to-dword
// conversion and the 10-bit TLP length encoding.
package dlsc_pcie_s6_outbound_read_split_pkg;

  // PCIe Max Read Request Size field encodings
  typedef enum logic [2:0] {
    MRRS_128  = 3'd0,
    MRRS_256  = 3'd1,
    MRRS_512  = 3'd2,
    MRRS_1024 = 3'd3,
    MRRS_2048 = 3'd4,
    MRRS_4096 = 3'd5
  } mrrs_e;

  // Splitter control states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_e;

  // MRRS encoding to dwords; reserved encodings fall back to 128 bytes
  function automatic logic [10:0] mrrs_to_dw(input logic [2:0] enc);
    logic [10:0] dw;
    if (enc > MRRS_4096) dw = 11'd32;
    else                 dw = 11'd32 << enc;
    return dw;
  endfunction

  // TLP length field: 1024 dwords is encoded as 0
  function automatic logic [9:0] len_encode(input logic [10:0] dw);
    return (dw == 11'd1024) ? 10'd0 : dw[9:0];
  endfunction

endpackage

// File: rtl/dlsc_pcie_s6_read_seg_calc.sv
// Segment length for one read request: the smaller of the remaining
// dword count and the room left before the next MRRS-aligned boundary.
module dlsc_pcie_s6_read_seg_calc #(
  parameter int LEN = 12
) (
  input  logic [9:0]   addr_lo,
  input  logic [10:0]  mrrs_dw,
  input  logic [LEN:0] rem,
  output logic [10:0]  seg
);

  logic [9:0]  mask;
  logic [10:0] room;

  // room = mrrs_dw - (addr mod mrrs_dw); seg = min(rem, room)
  always_comb begin
    mask = 10'(mrrs_dw - 11'd1);
    room = mrrs_dw - {1'b0, addr_lo & mask};
    if (rem < (LEN+1)'(room)) seg = rem[10:0];
    else                      seg = room;
  end

endmodule

// File: rtl/dlsc_pcie_s6_outbound_read_split.sv
// Splits outbound DMA read commands into MRRS-sized, MRRS-aligned read
// request headers, one header per tlp_h handshake.
module dlsc_pcie_s6_outbound_read_split
  import dlsc_pcie_s6_outbound_read_split_pkg::*;
#(
  parameter int ADDR = 32,
  parameter int LEN  = 12
) (
  input  logic            clk,
  input  logic            rst,
  output logic            cmd_ready,
  input  logic            cmd_valid,
  input  logic [ADDR-1:2] cmd_addr,
  input  logic [LEN-1:0]  cmd_len,
  output logic            cmd_done,
  input  logic            tlp_h_ready,
  output logic            tlp_h_valid,
  output logic [ADDR-1:2] tlp_h_addr,
  output logic [9:0]      tlp_h_len,
  input  logic [2:0]      max_read_req,
  input  logic            dma_en,
  output logic            busy
);

  localparam int AW = ADDR - 2;
  localparam int RW = LEN + 1;

  split_state_e    state, state_next;
  logic [AW-1:0]   cur_addr;     // start of the next segment to present
  logic [RW-1:0]   rem;          // dwords not yet presented
  logic [10:0]     mrrs_dw;      // MRRS latched for the running command
  logic            last_q;       // presented header is the command's last

  logic [AW-1:0]   src_addr;
  logic [10:0]     calc_mrrs;
  logic [RW-1:0]   calc_rem;
  logic [10:0]     seg;
  logic            hdr_accept;
  logic            cmd_accept;
  logic            load_seg;
  logic            finish;

  assign hdr_accept = tlp_h_valid && tlp_h_ready;

  // Segment source: the incoming command while idle, running state otherwise
  always_comb begin
    if (state == ST_IDLE) begin
      src_addr  = cmd_addr;
      calc_mrrs = mrrs_to_dw(max_read_req);
      calc_rem  = {1'b0, cmd_len} + RW'(1);
    end else begin
      src_addr  = cur_addr;
      calc_mrrs = mrrs_dw;
      calc_rem  = rem;
    end
  end

  dlsc_pcie_s6_read_seg_calc #(
    .LEN (LEN)
  ) u_seg_calc (
    .addr_lo (src_addr[9:0]),
    .mrrs_dw (calc_mrrs),
    .rem     (calc_rem),
    .seg     (seg)
  );

  // Next-state and control decode
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_next = state;
    cmd_ready  = 1'b0;
    cmd_accept = 1'b0;
    load_seg   = 1'b0;
    finish     = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready  = dma_en && !rst;
        cmd_accept = cmd_valid && cmd_ready;
        load_seg   = cmd_accept;
        if (cmd_accept) state_next = ST_SPLIT;
      end
      ST_SPLIT: begin
        busy = 1'b1;
        if (hdr_accept && last_q) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end else if ((!tlp_h_valid || hdr_accept) && dma_en) begin
          load_seg = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Header valid and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      tlp_h_valid <= 1'b0;
      cmd_done    <= 1'b0;
    end else begin
      cmd_done <= finish;
      if (load_seg)        tlp_h_valid <= 1'b1;
      else if (hdr_accept) tlp_h_valid <= 1'b0;
    end
  end

  // Header fields and split bookkeeping
  always_ff @(posedge clk) begin
    // NOTE: datapath registers have no reset; they are only read once a load has qualified them.
    if (load_seg) begin
      tlp_h_addr <= src_addr;
      tlp_h_len  <= len_encode(seg);
      cur_addr   <= src_addr + AW'(seg);
      rem        <= calc_rem - RW'(seg);
      last_q     <= (calc_rem == RW'(seg));
    end
    if (cmd_accept) mrrs_dw <= calc_mrrs;
  end

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_read_split.sv
// Self-checking bench for dlsc_pcie_s6_outbound_read_split: directed cases
// followed by randomized commands, all checked against a header-list model.
module tb_dlsc_pcie_s6_outbound_read_split;

  localparam int ADDR = 32;
  localparam int LEN  = 12;
  localparam int AW   = ADDR - 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_ready;
  logic            cmd_valid;
  logic [AW-1:0]   cmd_addr;
  logic [LEN-1:0]  cmd_len;
  logic            cmd_done;
  logic            tlp_h_ready;
  logic            tlp_h_valid;
  logic [AW-1:0]   tlp_h_addr;
  logic [9:0]      tlp_h_len;
  logic [2:0]      max_read_req;
  logic            dma_en;
  logic            busy;

  always #5 clk = ~clk;

  dlsc_pcie_s6_outbound_read_split #(
    .ADDR (ADDR),
    .LEN  (LEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_ready    (cmd_ready),
    .cmd_valid    (cmd_valid),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_done     (cmd_done),
    .tlp_h_ready  (tlp_h_ready),
    .tlp_h_valid  (tlp_h_valid),
    .tlp_h_addr   (tlp_h_addr),
    .tlp_h_len    (tlp_h_len),
    .max_read_req (max_read_req),
    .dma_en       (dma_en),
    .busy         (busy)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [9:0]    len;
    bit            last;
  } hdr_t;

  hdr_t          exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            hdr_cnt = 0;
  bit            done_exp = 0;
  bit            hold_exp = 0;
  bit            idle_exp = 0;
  bit            rand_ready = 0;
  bit            rand_dma = 0;
  logic [AW-1:0] hold_addr;
  logic [9:0]    hold_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected header list for one command, straight from the splitting rule
  task automatic model_cmd(input logic [AW-1:0] a0, input int unsigned l, input int unsigned enc);
    longint a = longint'(a0);
    int     r = int'(l) + 1;
    int     m = (enc > 5) ? 32 : (32 << enc);
    int     room;
    int     s;
    hdr_t   h;
    while (r > 0) begin
      room   = m - int'(a % m);
      s      = (r < room) ? r : room;
      h.addr = a[AW-1:0];
      h.len  = (s == 1024) ? 10'd0 : 10'(s);
      h.last = (r == s);
      exp_q.push_back(h);
      a = (a + s) & 64'h3FFF_FFFF;
      r = r - s;
    end
  endtask

  // Called once per cycle with this cycle's inputs final, before the edge
  task automatic monitor();
    hdr_t h;
    check("cmd_done", 32'(cmd_done), 32'(done_exp));
    if (hold_exp) begin
      check("hold_valid", 32'(tlp_h_valid), 1);
      check("hold_addr", 32'(tlp_h_addr), 32'(hold_addr));
      check("hold_len", 32'(tlp_h_len), 32'(hold_len));
    end
    if (idle_exp) check("no_new_hdr", 32'(tlp_h_valid), 0);
    done_exp = 0;
    hold_exp = 0;
    idle_exp = 0;
    if (!rst) begin
      if (tlp_h_valid && tlp_h_ready) begin
        check("hdr_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          h = exp_q.pop_front();
          hdr_cnt++;
          check("hdr_addr", 32'(tlp_h_addr), 32'(h.addr));
          check("hdr_len", 32'(tlp_h_len), 32'(h.len));
          done_exp = h.last;
          idle_exp = h.last;
        end
      end
      hold_exp  = tlp_h_valid && !tlp_h_ready;
      hold_addr = tlp_h_addr;
      hold_len  = tlp_h_len;
      if ((!tlp_h_valid || tlp_h_ready) && !dma_en) idle_exp = 1;
    end
  endtask

  task automatic tick();
    monitor();
    @(negedge clk);
    if (rand_ready) tlp_h_ready = ($urandom_range(0, 3) != 0);
    if (rand_dma)   dma_en      = ($urandom_range(0, 7) != 0);
    #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LEN-1:0] l, input logic [2:0] enc);
    int guard = 0;
    cmd_addr     = a;
    cmd_len      = l;
    max_read_req = enc;
    cmd_valid    = 1'b1;
    #1;
    while (!cmd_ready && guard < 200) begin
      tick();
      guard++;
    end
    check("cmd_accept_timeout", 32'(guard < 200), 1);
    model_cmd(a, 32'(l), 32'(enc));
    tick();
    cmd_valid    = 1'b0;
    cmd_addr     = AW'($urandom);
    cmd_len      = LEN'($urandom);
    max_read_req = 3'($urandom_range(0, 7));
    #1;
  endtask

  task automatic run_until_done(input string tag);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 20000) begin
      tick();
      guard++;
    end
    check(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_addr     = '0;
    cmd_len      = '0;
    tlp_h_ready  = 1'b0;
    max_read_req = 3'd0;
    dma_en       = 1'b1;
    @(negedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(tlp_h_valid), 0);
    check("rst_done", 32'(cmd_done), 0);
    check("rst_busy", 32'(busy), 0);
    check("idle_cmd_ready", 32'(cmd_ready), 1);

    // 512B MRRS, 256 dwords from 0 -> two 128-dword headers
    tlp_h_ready = 1'b1;
    hdr_cnt = 0;
    send_cmd(30'h000, 12'd255, 3'd2);
    check("t1_first_valid", 32'(tlp_h_valid), 1);
    check("t1_busy", 32'(busy), 1);
    run_until_done("t1_complete");
    check("t1_hdrs", 32'(hdr_cnt), 2);
    check("t1_ready_with_done", 32'(cmd_ready), 1);

    // 4KB MRRS, 32 dwords at 0x3F0 -> split at the 0x400 boundary
    hdr_cnt = 0;
    send_cmd(30'h3F0, 12'd31, 3'd5);
    run_until_done("t2_complete");
    check("t2_hdrs", 32'(hdr_cnt), 2);

    // 4KB MRRS, 4096 dwords -> four 1024-dword headers (len field 0)
    hdr_cnt = 0;
    send_cmd(30'h000, 12'd4095, 3'd5);
    run_until_done("t3_complete");
    check("t3_hdrs", 32'(hdr_cnt), 4);

    // Ready held low for 5 cycles, then back-to-back acceptance
    tlp_h_ready = 1'b0;
    hdr_cnt = 0;
    send_cmd(30'h010, 12'd127, 3'd0);
    repeat (5) tick();
    check("t4_held_cnt", 32'(hdr_cnt), 0);
    tlp_h_ready = 1'b1;
    repeat (5) tick();
    check("t4_b2b_cnt", 32'(hdr_cnt), 5);

    // dma_en dropped while the second of four headers is presented
    hdr_cnt = 0;
    send_cmd(30'h000, 12'd127, 3'd0);
    tick();
    tlp_h_ready = 1'b0;
    dma_en      = 1'b0;
    repeat (3) tick();
    tlp_h_ready = 1'b1;
    tick();
    repeat (3) tick();
    check("t5_paused_cnt", 32'(hdr_cnt), 2);
    check("t5_paused_busy", 32'(busy), 1);
    check("t5_paused_valid", 32'(tlp_h_valid), 0);
    dma_en = 1'b1;
    run_until_done("t5_complete");
    check("t5_hdrs", 32'(hdr_cnt), 4);

    // Reset with 200 dwords outstanding
    tick();
    hdr_cnt = 0;
    send_cmd(30'h000, 12'd231, 3'd0);
    tick();
    tlp_h_ready = 1'b0;
    rst = 1'b1;
    #1;
    tick();
    exp_q.delete();
    check("t6_valid", 32'(tlp_h_valid), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_ready_in_rst", 32'(cmd_ready), 0);
    rst = 1'b0;
    #1;
    check("t6_ready_after", 32'(cmd_ready), 1);
    tick();
    check("t6_no_done", 32'(cmd_done), 0);
    tlp_h_ready = 1'b1;
    hdr_cnt = 0;
    send_cmd(30'h07F, 12'd9, 3'd1);
    run_until_done("t6_complete");
    check("t6_hdrs", 32'(hdr_cnt), 2);

    // Randomized commands with random ready, dma_en and MRRS
    rand_ready = 1;
    rand_dma   = 1;
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0]  a;
      logic [LEN-1:0] l;
      a = ($urandom_range(0, 3) == 0) ? (30'h3FFF_FF00 | AW'($urandom_range(0, 255))) : AW'($urandom);
      l = ($urandom_range(0, 3) == 0) ? LEN'($urandom_range(0, 4095)) : LEN'($urandom_range(0, 300));
      send_cmd(a, l, 3'($urandom_range(0, 7)));
      run_until_done("rand_complete");
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_ready  = 0;
    rand_dma    = 0;
    dma_en      = 1'b1;
    tlp_h_ready = 1'b1;
    repeat (3) tick();
    check("final_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
